// File: rtl/atm_pkg.sv
// Shared ATM definitions: keypad key codes, keypad FSM states, controller message codes.
package atm_pkg;

    localparam int unsigned KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_CLR  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_BACK = 4'hB;
    localparam logic [KEY_W-1:0] KEY_ENT  = 4'hC;

    typedef enum logic [1:0] {
        KP_IDLE    = 2'd0,
        KP_COLLECT = 2'd1,
        KP_CONV    = 2'd2,
        KP_PULSE   = 2'd3
    } kp_state_t;

    typedef enum logic [3:0] {
        MSG_WELCOME   = 4'd0,
        MSG_ENTER_PIN = 4'd1,
        MSG_PIN_OK    = 4'd2,
        MSG_PIN_BAD   = 4'd3,
        MSG_MENU      = 4'd4,
        MSG_ENTER_AMT = 4'd5,
        MSG_DISPENSE  = 4'd6,
        MSG_NO_FUNDS  = 4'd7,
        MSG_EJECT     = 4'd8
    } atm_msg_t;

    // Decimal digit keys are 0..9
    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Serial BCD-to-binary converter: one decimal digit per cycle, most significant first.
module bcd_to_bin_seq #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned CODE_W     = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [MAX_DIGITS-1:0][3:0] digits,
    input  logic [2:0]                 cnt,
    output logic [CODE_W-1:0]          acc,
    output logic                       done
);

    localparam int unsigned IDX_W  = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int unsigned WIDE_W = CODE_W + 4;

    logic             busy;
    logic [IDX_W-1:0] idx;
    logic [CODE_W-1:0] acc_next_c;
    logic             last_c;

    // acc*10 + digit as shift-add, widened so the sum cannot wrap before truncation
    always_comb begin
        acc_next_c = CODE_W'((WIDE_W'(acc) << 3) + (WIDE_W'(acc) << 1) + WIDE_W'(digits[idx]));
        last_c     = (3'(idx) == (cnt - 3'd1));
    end

    // Step through the buffered digits; done pulses once after the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (abort) begin
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            acc <= acc_next_c;
            idx <= idx + IDX_W'(1);
            if (last_c) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry front end: buffers digits, handles edit keys, converts and submits a code.
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int unsigned MAX_DIGITS  = 4,
    parameter int unsigned CODE_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              card,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              key_ready,
    output logic [CODE_W-1:0] code,
    output logic              enter,
    output logic [2:0]        digit_cnt,
    output logic              err,
    output logic              timeout
);

    localparam int unsigned IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int unsigned TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [2:0]  MAX_CNT = 3'(MAX_DIGITS);

    kp_state_t                 state_q, state_d;
    logic [MAX_DIGITS-1:0][3:0] dig_q, dig_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [TO_W-1:0]           idle_q, idle_d;
    logic [CODE_W-1:0]         code_q, code_d;
    logic                      ready_q, ready_d;
    logic                      enter_q, enter_d;
    logic                      err_q, err_d;
    logic                      timeout_q, timeout_d;
    logic                      accept_c;
    logic                      conv_start_c;
    logic                      abort_c;
    logic                      conv_done;
    logic [CODE_W-1:0]         conv_acc;

    assign abort_c = ~card;

    bcd_to_bin_seq #(
        .MAX_DIGITS (MAX_DIGITS),
        .CODE_W     (CODE_W)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start_c),
        .abort  (abort_c),
        .digits (dig_q),
        .cnt    (cnt_q),
        .acc    (conv_acc),
        .done   (conv_done)
    );

    // State, buffer, idle counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KP_IDLE;
            dig_q     <= '0;
            cnt_q     <= '0;
            idle_q    <= '0;
            code_q    <= '0;
            ready_q   <= 1'b0;
            enter_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            code_q    <= code_d;
            ready_q   <= ready_d;
            enter_q   <= enter_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and next output values; card removal overrides everything
    always_comb begin
        state_d      = state_q;
        dig_d        = dig_q;
        cnt_d        = cnt_q;
        idle_d       = idle_q;
        code_d       = code_q;
        enter_d      = 1'b0;
        err_d        = 1'b0;
        timeout_d    = 1'b0;
        conv_start_c = 1'b0;
        accept_c     = key_valid & ready_q;

        case (state_q)
            KP_IDLE: begin
                if (card) state_d = KP_COLLECT;
            end
            KP_COLLECT: begin
                if (accept_c) begin
                    idle_d = '0;
                    if (is_digit(key_code)) begin
                        if (cnt_q < MAX_CNT) begin
                            dig_d[IDX_W'(cnt_q)] = key_code;
                            cnt_d                = cnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_code == KEY_CLR) begin
                        cnt_d = '0;
                    end else if (key_code == KEY_BACK) begin
                        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                    end else if (key_code == KEY_ENT) begin
                        if (cnt_q != 3'd0) begin
                            state_d      = KP_CONV;
                            conv_start_c = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q != 3'd0) begin
                    if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        cnt_d     = '0;
                        idle_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_q + TO_W'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            KP_CONV: begin
                if (conv_done) begin
                    state_d = KP_PULSE;
                    code_d  = conv_acc;
                    enter_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            KP_PULSE: begin
                state_d = KP_COLLECT;
            end
            default: begin
                state_d = KP_IDLE;
            end
        endcase

        if (!card) begin
            state_d      = KP_IDLE;
            dig_d        = '0;
            cnt_d        = '0;
            idle_d       = '0;
            code_d       = '0;
            enter_d      = 1'b0;
            err_d        = 1'b0;
            timeout_d    = 1'b0;
            conv_start_c = 1'b0;
        end

        ready_d = (state_d == KP_COLLECT);
    end

    assign key_ready = ready_q;
    assign code      = code_q;
    assign enter     = enter_q;
    assign digit_cnt = cnt_q;
    assign err       = err_q;
    assign timeout   = timeout_q;

endmodule
